// File: rtl/pipe_stage_buffer_if.sv
// ============================================================================
// Module : pipe_stage_buffer_if
// Brief  : Valid/ready handshake bundle for one pipeline-stage buffer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface pipe_stage_buffer_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  // slave is the buffer's view; master is the surrounding pipeline's view
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

`default_nettype wire

// File: rtl/pipe_stage_buffer.sv
// ============================================================================
// Module : pipe_stage_buffer
// Brief  : Parametrised pipeline-stage register with optional skid entry.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_stage_buffer #(
  parameter int WIDTH = 64,
  parameter int SKID  = 1
) (
  input  wire logic          clk,
  input  wire logic          reset,
  input  wire logic          flush,
  pipe_stage_buffer_if.slave bus,
  output logic [1:0]         occupancy
);

  // State encoding doubles as the occupancy count
  localparam logic [1:0] c_EMPTY = 2'd0;
  localparam logic [1:0] c_ONE   = 2'd1;
  localparam logic [1:0] c_FULL  = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] w_skid_q;
  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_accept;
  logic             w_emit;
  logic             w_load_main;
  logic             w_main_from_skid;
  logic             w_load_skid;

  assign w_out_valid = (r_state != c_EMPTY);
  assign w_accept    = bus.in_valid & w_in_ready;
  assign w_emit      = w_out_valid & bus.out_ready;

  always_comb begin
    w_state_nxt      = r_state;
    w_load_main      = 1'b0;
    w_main_from_skid = 1'b0;
    w_load_skid      = 1'b0;
    case (r_state)
      c_EMPTY: begin
        if (w_accept) begin
          w_state_nxt = c_ONE;
          w_load_main = 1'b1;
        end
      end
      c_ONE: begin
        if (w_accept && w_emit) begin
          w_load_main = 1'b1;
        end else if (w_accept) begin
          if (SKID != 0) begin
            w_state_nxt = c_FULL;
            w_load_skid = 1'b1;
          end
        end else if (w_emit) begin
          w_state_nxt = c_EMPTY;
        end
      end
      c_FULL: begin
        if (w_emit) begin
          w_state_nxt      = c_ONE;
          w_load_main      = 1'b1;
          w_main_from_skid = 1'b1;
        end
      end
      default: w_state_nxt = c_EMPTY;
    endcase
    // Squash wins: any word accepted this cycle is dropped with the rest
    if (flush) begin
      w_state_nxt = c_EMPTY;
      w_load_main = 1'b0;
      w_load_skid = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A flush of a live entry leaves a zero NOP bubble; an empty stage keeps its last word
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_main <= '0;
    end else if (flush && (r_state != c_EMPTY)) begin
      r_main <= '0;
    end else if (w_load_main) begin
      r_main <= w_main_from_skid ? w_skid_q : bus.in_data;
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      logic [WIDTH-1:0] r_skid;
      logic             r_in_ready;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_skid <= '0;
        end else if (flush) begin
          r_skid <= '0;
        end else if (w_load_skid) begin
          r_skid <= bus.in_data;
        end
      end

      // Registered ready cuts the out_ready -> in_ready timing path
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_in_ready <= 1'b1;
        end else begin
          r_in_ready <= (w_state_nxt != c_FULL);
        end
      end

      assign w_skid_q   = r_skid;
      assign w_in_ready = r_in_ready;
    end else begin : g_single
      assign w_skid_q   = '0;
      assign w_in_ready = ~w_out_valid | bus.out_ready;
    end
  endgenerate

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = r_main;
  assign occupancy     = r_state;

endmodule

`default_nettype wire
